// File: rtl/router_pkt_packer.sv
`default_nettype none
// ============================================================================
// Module   : router_pkt_packer
// Purpose  : Ingress packer in front of the 3-port router. It accepts a
//            command (destination, length) and the payload bytes. It buffers
//            the whole payload, then streams header, payload and parity with
//            no bubbles while obeying the router's busy.
// Ports    : clock, reset          - clock, synchronous active-high reset
//            cmd_valid/ready/addr/len, cmd_err - command handshake, drop pulse
//            pl_valid/ready/data   - payload byte handshake
//            busy                  - router busy, stalls the output stream
//            pkt_data/pkt_valid    - to router data_in / pkt_valid
//            pkt_done              - pulse when the parity byte is consumed
//            inject_err            - only with ROUTER_PKT_PACKER_ERR_INJECT_EN:
//                                    corrupt this packet's parity byte
// Macro    : ROUTER_PKT_PACKER_ERR_INJECT_EN (optional parity error injection)
// Revision : 1.0 - initial release
// ============================================================================
module router_pkt_packer #(
  parameter int IPG   = 1,   // idle cycles after each parity byte, 1..15
  parameter int DEPTH = 64   // payload buffer entries, >= 63
) (
  input  logic       clock,
  input  logic       reset,
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
  input  logic       inject_err,
`endif
  input  logic       cmd_valid,
  output logic       cmd_ready,
  input  logic [1:0] cmd_addr,
  input  logic [5:0] cmd_len,
  output logic       cmd_err,
  input  logic       pl_valid,
  output logic       pl_ready,
  input  logic [7:0] pl_data,
  input  logic       busy,
  output logic [7:0] pkt_data,
  output logic       pkt_valid,
  output logic       pkt_done
);

  localparam int       AW     = $clog2(DEPTH);
  localparam logic [3:0] IPG_M1 = 4'(IPG - 1);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_LOAD = 3'd1,
    S_HDR  = 3'd2,
    S_PAY  = 3'd3,
    S_PAR  = 3'd4,
    S_GAP  = 3'd5
  } state_t;

  state_t      state_q, state_d;
  logic [7:0]  hdr_q, hdr_d;
  logic [7:0]  par_q, par_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [3:0]  gap_q, gap_d;
  logic        cmd_ready_q, cmd_ready_d;
  logic        pl_ready_q, pl_ready_d;
  logic        cmd_err_q, cmd_err_d;
  logic [7:0]  pkt_data_q, pkt_data_d;
  logic        pkt_valid_q, pkt_valid_d;
  logic        pkt_done_q, pkt_done_d;
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
  logic        inj_q, inj_d;
`endif

  logic [7:0]  buf_q [DEPTH];
  logic        buf_we;
  logic [AW-1:0] rd_addr;
  logic [7:0]  rd_data;
  logic [5:0]  len_m1;
  logic [7:0]  par_out;

  // Header layout is {len, addr}, so the length lives in the top six bits.
  assign len_m1  = hdr_q[7:2] - 6'd1;

  // The read port looks one byte ahead of the byte currently on pkt_data so
  // the next byte is ready to be registered when the current one is consumed.
  // In HDR the lookahead target is entry 0.
  assign rd_addr = (state_q == S_PAY) ? AW'(cnt_q + 6'd1) : '0;
  assign rd_data = buf_q[rd_addr];

`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
  assign par_out = inj_q ? ~par_q : par_q;
`else
  assign par_out = par_q;
`endif

  always_comb begin
    state_d     = state_q;
    hdr_d       = hdr_q;
    par_d       = par_q;
    cnt_d       = cnt_q;
    gap_d       = gap_q;
    cmd_ready_d = cmd_ready_q;
    pl_ready_d  = pl_ready_q;
    cmd_err_d   = 1'b0;
    pkt_done_d  = 1'b0;
    pkt_data_d  = pkt_data_q;   // held while busy stalls the router
    pkt_valid_d = pkt_valid_q;
    buf_we      = 1'b0;
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
    inj_d       = inj_q;
`endif
    unique case (state_q)
      S_IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_valid && cmd_ready_q) begin
          if (cmd_len == 6'd0 || cmd_addr == 2'd3) begin
            cmd_err_d = 1'b1;
          end else begin
            hdr_d       = {cmd_len, cmd_addr};
            par_d       = {cmd_len, cmd_addr};
            cnt_d       = 6'd0;
            state_d     = S_LOAD;
            cmd_ready_d = 1'b0;
            pl_ready_d  = 1'b1;
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
            inj_d       = inject_err;
`endif
          end
        end
      end
      S_LOAD: begin
        if (pl_valid && pl_ready_q) begin
          buf_we = 1'b1;
          par_d  = par_q ^ pl_data;
          cnt_d  = cnt_q + 6'd1;
          if (cnt_q == len_m1) begin
            state_d     = S_HDR;
            pl_ready_d  = 1'b0;
            pkt_data_d  = hdr_q;
            pkt_valid_d = 1'b1;
          end
        end
      end
      S_HDR: begin
        if (!busy) begin
          state_d    = S_PAY;
          pkt_data_d = rd_data;
          cnt_d      = 6'd0;
        end
      end
      S_PAY: begin
        if (!busy) begin
          if (cnt_q != len_m1) begin
            pkt_data_d = rd_data;
            cnt_d      = cnt_q + 6'd1;
          end else begin
            state_d     = S_PAR;
            pkt_valid_d = 1'b0;
            pkt_data_d  = par_out;
          end
        end
      end
      S_PAR: begin
        if (!busy) begin
          state_d    = S_GAP;
          pkt_done_d = 1'b1;
          pkt_data_d = 8'h00;
          gap_d      = 4'd0;
        end
      end
      S_GAP: begin
        // Inter-packet gap runs on cycles, not on router consumption.
        if (gap_q == IPG_M1) begin
          state_d     = S_IDLE;
          cmd_ready_d = 1'b1;
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
          inj_d       = 1'b0;
`endif
        end else begin
          gap_d = gap_q + 4'd1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q     <= S_IDLE;
      hdr_q       <= 8'h00;
      par_q       <= 8'h00;
      cnt_q       <= 6'd0;
      gap_q       <= 4'd0;
      cmd_ready_q <= 1'b0;
      pl_ready_q  <= 1'b0;
      cmd_err_q   <= 1'b0;
      pkt_data_q  <= 8'h00;
      pkt_valid_q <= 1'b0;
      pkt_done_q  <= 1'b0;
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
      inj_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      hdr_q       <= hdr_d;
      par_q       <= par_d;
      cnt_q       <= cnt_d;
      gap_q       <= gap_d;
      cmd_ready_q <= cmd_ready_d;
      pl_ready_q  <= pl_ready_d;
      cmd_err_q   <= cmd_err_d;
      pkt_data_q  <= pkt_data_d;
      pkt_valid_q <= pkt_valid_d;
      pkt_done_q  <= pkt_done_d;
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
      inj_q       <= inj_d;
`endif
    end
  end

  // Payload storage carries no reset; stale contents are never read because
  // the read side only walks entries written for the current packet.
  always_ff @(posedge clock) begin
    if (buf_we) begin
      buf_q[AW'(cnt_q)] <= pl_data;
    end
  end

  assign cmd_ready = cmd_ready_q;
  assign pl_ready  = pl_ready_q;
  assign cmd_err   = cmd_err_q;
  assign pkt_data  = pkt_data_q;
  assign pkt_valid = pkt_valid_q;
  assign pkt_done  = pkt_done_q;

endmodule
`default_nettype wire

// File: tb/tb_router_pkt_packer.sv
`default_nettype none
// ============================================================================
// Module   : tb_router_pkt_packer
// Purpose  : Self-checking bench for router_pkt_packer. A per-cycle vector
//            table covers the basic packet, a busy stall and illegal
//            commands; hand-written sequences cover max length with payload
//            gaps, reset mid-packet and (when enabled) parity injection.
// Revision : 1.0 - initial release
// ============================================================================
module tb_router_pkt_packer;

  logic       clock = 1'b0;
  logic       reset;
  logic       inject_err;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [1:0] cmd_addr;
  logic [5:0] cmd_len;
  logic       cmd_err;
  logic       pl_valid;
  logic       pl_ready;
  logic [7:0] pl_data;
  logic       busy;
  logic [7:0] pkt_data;
  logic       pkt_valid;
  logic       pkt_done;

  router_pkt_packer #(.IPG(1), .DEPTH(64)) dut (
    .clock     (clock),
    .reset     (reset),
`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
    .inject_err(inject_err),
`endif
    .cmd_valid (cmd_valid),
    .cmd_ready (cmd_ready),
    .cmd_addr  (cmd_addr),
    .cmd_len   (cmd_len),
    .cmd_err   (cmd_err),
    .pl_valid  (pl_valid),
    .pl_ready  (pl_ready),
    .pl_data   (pl_data),
    .busy      (busy),
    .pkt_data  (pkt_data),
    .pkt_valid (pkt_valid),
    .pkt_done  (pkt_done)
  );

  always #5 clock = ~clock;

  // One row per cycle: inputs driven after a falling edge, and the outputs
  // expected to be showing during that same cycle.
  typedef struct {
    logic       cv;
    logic [1:0] ca;
    logic [5:0] cl;
    logic       pv;
    logic [7:0] pd;
    logic       bz;
    logic       e_cr;
    logic       e_pr;
    logic       e_ce;
    logic [7:0] e_pd;
    logic       e_pv;
    logic       e_dn;
  } vec_t;

  localparam int NV = 26;
  vec_t tbl [NV];

  int checks   = 0;
  int failures = 0;
  logic [7:0] exp_pl [64];

  task automatic chk8(input string name, input logic [7:0] act, input logic [7:0] exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got 0x%02h expected 0x%02h", name, act, exp_v);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp_v);
    checks++;
    if (act !== exp_v) begin
      failures++;
      $display("FAIL %s: got %b expected %b", name, act, exp_v);
    end
  endtask

  function automatic vec_t mk(input logic cv, input logic [1:0] ca, input logic [5:0] cl,
                              input logic pv, input logic [7:0] pd, input logic bz,
                              input logic e_cr, input logic e_pr, input logic e_ce,
                              input logic [7:0] e_pd, input logic e_pv, input logic e_dn);
    vec_t v;
    v.cv = cv; v.ca = ca; v.cl = cl; v.pv = pv; v.pd = pd; v.bz = bz;
    v.e_cr = e_cr; v.e_pr = e_pr; v.e_ce = e_ce;
    v.e_pd = e_pd; v.e_pv = e_pv; v.e_dn = e_dn;
    return v;
  endfunction

  task automatic idle_inputs();
    cmd_valid = 1'b0; cmd_addr = 2'd0; cmd_len = 6'd0;
    pl_valid = 1'b0; pl_data = 8'h00; busy = 1'b0; inject_err = 1'b0;
  endtask

  // Entered at a falling edge; waits (bounded) for cmd_ready, then offers
  // the command for exactly one cycle.
  task automatic send_cmd(input logic [1:0] a, input logic [5:0] l, input logic inj);
    int k = 0;
    while (cmd_ready !== 1'b1 && k < 50) begin
      @(negedge clock);
      k++;
    end
    chk1("cmd_ready_wait", cmd_ready, 1'b1);
    cmd_valid = 1'b1; cmd_addr = a; cmd_len = l; inject_err = inj;
    @(negedge clock);
    cmd_valid = 1'b0; inject_err = 1'b0;
  endtask

  // Sends exp_pl[0..len-1]; with gaps, every odd byte is preceded by an
  // idle pl_valid cycle. Returns at the cycle after the last handshake.
  task automatic send_payload(input int len, input logic gaps);
    for (int i = 0; i < len; i++) begin
      if (gaps && i[0]) begin
        pl_valid = 1'b0;
        @(negedge clock);
      end
      chk1("pl_ready_load", pl_ready, 1'b1);
      pl_valid = 1'b1; pl_data = exp_pl[i];
      @(negedge clock);
    end
    pl_valid = 1'b0;
  endtask

  // Entered at the cycle where the header must already be showing.
  task automatic expect_pkt(input logic [7:0] hdr, input int len, input logic [7:0] par);
    chk8("hdr_data", pkt_data, hdr);
    chk1("hdr_valid", pkt_valid, 1'b1);
    chk1("pl_ready_off", pl_ready, 1'b0);
    for (int i = 0; i < len; i++) begin
      @(negedge clock);
      chk8("pay_data", pkt_data, exp_pl[i]);
      chk1("pay_valid", pkt_valid, 1'b1);
    end
    @(negedge clock);
    chk8("par_data", pkt_data, par);
    chk1("par_valid", pkt_valid, 1'b0);
    chk1("par_done_early", pkt_done, 1'b0);
    @(negedge clock);
    chk1("done_pulse", pkt_done, 1'b1);
    chk8("gap_data", pkt_data, 8'h00);
    chk1("gap_cmd_ready", cmd_ready, 1'b0);
    @(negedge clock);
    chk1("cmd_ready_back", cmd_ready, 1'b1);
    chk1("done_clear", pkt_done, 1'b0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    //         cv ca cl pv pd     bz  cr pr ce pd     pv dn
    tbl[0]  = mk(1, 1, 3, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0);
    tbl[1]  = mk(0, 0, 0, 1, 8'h11, 0,  0, 1, 0, 8'h00, 0, 0);
    tbl[2]  = mk(0, 0, 0, 1, 8'h22, 0,  0, 1, 0, 8'h00, 0, 0);
    tbl[3]  = mk(0, 0, 0, 1, 8'h33, 0,  0, 1, 0, 8'h00, 0, 0);
    tbl[4]  = mk(1, 2, 7, 1, 8'h77, 0,  0, 0, 0, 8'h0D, 1, 0);
    tbl[5]  = mk(1, 2, 7, 1, 8'h77, 0,  0, 0, 0, 8'h11, 1, 0);
    tbl[6]  = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h22, 1, 0);
    tbl[7]  = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h33, 1, 0);
    tbl[8]  = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h0D, 0, 0);
    tbl[9]  = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1);
    tbl[10] = mk(1, 1, 3, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0);
    tbl[11] = mk(0, 0, 0, 1, 8'h11, 0,  0, 1, 0, 8'h00, 0, 0);
    tbl[12] = mk(0, 0, 0, 1, 8'h22, 0,  0, 1, 0, 8'h00, 0, 0);
    tbl[13] = mk(0, 0, 0, 1, 8'h33, 0,  0, 1, 0, 8'h00, 0, 0);
    tbl[14] = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h0D, 1, 0);
    tbl[15] = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h11, 1, 0);
    tbl[16] = mk(0, 0, 0, 0, 8'h00, 1,  0, 0, 0, 8'h22, 1, 0);
    tbl[17] = mk(0, 0, 0, 0, 8'h00, 1,  0, 0, 0, 8'h22, 1, 0);
    tbl[18] = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h22, 1, 0);
    tbl[19] = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h33, 1, 0);
    tbl[20] = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h0D, 0, 0);
    tbl[21] = mk(0, 0, 0, 0, 8'h00, 0,  0, 0, 0, 8'h00, 0, 1);
    tbl[22] = mk(1, 3, 5, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0);
    tbl[23] = mk(1, 0, 0, 0, 8'h00, 0,  1, 0, 1, 8'h00, 0, 0);
    tbl[24] = mk(0, 0, 0, 1, 8'hFF, 0,  1, 0, 1, 8'h00, 0, 0);
    tbl[25] = mk(0, 0, 0, 0, 8'h00, 0,  1, 0, 0, 8'h00, 0, 0);

    idle_inputs();
    reset = 1'b1;
    repeat (3) @(negedge clock);
    chk1("rst_cmd_ready", cmd_ready, 1'b0);
    chk1("rst_pl_ready", pl_ready, 1'b0);
    chk1("rst_cmd_err", cmd_err, 1'b0);
    chk8("rst_pkt_data", pkt_data, 8'h00);
    chk1("rst_pkt_valid", pkt_valid, 1'b0);
    chk1("rst_pkt_done", pkt_done, 1'b0);
    reset = 1'b0;

    for (int r = 0; r < NV; r++) begin
      @(negedge clock);
      cmd_valid = tbl[r].cv; cmd_addr = tbl[r].ca; cmd_len = tbl[r].cl;
      pl_valid = tbl[r].pv; pl_data = tbl[r].pd; busy = tbl[r].bz;
      chk1($sformatf("row%0d_cmd_ready", r), cmd_ready, tbl[r].e_cr);
      chk1($sformatf("row%0d_pl_ready", r), pl_ready, tbl[r].e_pr);
      chk1($sformatf("row%0d_cmd_err", r), cmd_err, tbl[r].e_ce);
      chk8($sformatf("row%0d_pkt_data", r), pkt_data, tbl[r].e_pd);
      chk1($sformatf("row%0d_pkt_valid", r), pkt_valid, tbl[r].e_pv);
      chk1($sformatf("row%0d_pkt_done", r), pkt_done, tbl[r].e_dn);
    end
    @(negedge clock);
    idle_inputs();

    // Max length, payload with gaps: header 0xFE, parity 0xFE ^ 0x3F = 0xC1.
    for (int i = 0; i < 63; i++) exp_pl[i] = 8'(i);
    send_cmd(2'd2, 6'd63, 1'b0);
    send_payload(63, 1'b1);
    expect_pkt(8'hFE, 63, 8'hC1);

    // Reset while the payload is streaming.
    for (int i = 0; i < 4; i++) exp_pl[i] = 8'(i + 1);
    send_cmd(2'd2, 6'd4, 1'b0);
    send_payload(4, 1'b0);
    chk8("mid_hdr", pkt_data, 8'h12);
    @(negedge clock);
    chk1("mid_in_pay", pkt_valid, 1'b1);
    reset = 1'b1;
    @(negedge clock);
    reset = 1'b0;
    chk1("mid_rst_valid", pkt_valid, 1'b0);
    chk8("mid_rst_data", pkt_data, 8'h00);
    chk1("mid_rst_cmd_ready", cmd_ready, 1'b0);
    chk1("mid_rst_pl_ready", pl_ready, 1'b0);
    chk1("mid_rst_done", pkt_done, 1'b0);
    @(negedge clock);
    exp_pl[0] = 8'hA5;
    send_cmd(2'd0, 6'd1, 1'b0);
    send_payload(1, 1'b0);
    expect_pkt(8'h04, 1, 8'hA1);

`ifdef ROUTER_PKT_PACKER_ERR_INJECT_EN
    exp_pl[0] = 8'h11; exp_pl[1] = 8'h22; exp_pl[2] = 8'h33;
    send_cmd(2'd1, 6'd3, 1'b1);
    send_payload(3, 1'b0);
    expect_pkt(8'h0D, 3, 8'hF2);
    send_cmd(2'd1, 6'd3, 1'b0);
    send_payload(3, 1'b0);
    expect_pkt(8'h0D, 3, 8'h0D);
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/router_pkt_packer.md
Name: router_pkt_packer

Overview:
- Ingress stage directly upstream of the 3-port router top; drives the router's data_in and pkt_valid and obeys its busy.
- Takes a command (destination port and payload length) and payload bytes over valid/ready handshakes.
- Stores the whole payload first, then emits one router packet with no bubbles: header, payload, parity.
- Buffering first means pkt_valid never drops mid-packet.

Parameters:
- IPG, 1, idle cycles (pkt_valid=0, pkt_data=0) forced after each parity byte; legal range 1..15.
- DEPTH, 64, payload buffer entries; must be ≥63, the max 6-bit length.

Ports:
- clock  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- cmd_valid  in  1  command offered
- cmd_ready  out  1  command accepted when both are high
- cmd_addr  in  2  destination port, 0..2
- cmd_len  in  6  payload length, 1..63
- cmd_err  out  1  one-cycle pulse: illegal command dropped
- pl_valid  in  1  payload byte offered
- pl_ready  out  1  payload byte accepted when both are high
- pl_data  in  8  payload byte
- busy  in  1  router busy; no byte is consumed in a busy cycle
- pkt_data  out  8  to router data_in
- pkt_valid  out  1  to router pkt_valid
- pkt_done  out  1  one-cycle pulse when the parity byte is consumed

Behaviour:
- **Reset values:** all outputs are registered; reset drives every output to 0 (cmd_ready=0 during reset). The FSM returns to IDLE and the write/read pointers, byte counter and parity accumulator clear.
- **Reset mid-packet:** behaves the same; the packet is abandoned and pkt_valid is 0 on the next cycle.
- **Consume rule:** a byte on pkt_data is consumed on a rising edge where busy=0. When busy=1, pkt_data and pkt_valid hold unchanged.
- **IDLE:**
  - cmd_ready=1.
  - On handshake, if cmd_len==0 or cmd_addr==3: pulse cmd_err next cycle, stay in IDLE.
  - Otherwise latch hdr={cmd_len,cmd_addr}, set par=hdr, cnt=0, go to LOAD. cmd_ready drops next cycle.
- **LOAD:**
  - pl_ready=1.
  - Each handshake writes buf[cnt]=pl_data, par^=pl_data, cnt++.
  - When the byte with cnt==len-1 is accepted, go to HDR. pl_ready is 0 from that next cycle.
  - pl_valid gaps are allowed and only extend LOAD.
- **HDR:**
  - On entry pkt_data=hdr, pkt_valid=1.
  - On consume: go to PAY with pkt_data=buf[0], cnt=0.
- **PAY:**
  - pkt_valid=1 throughout.
  - On consume of byte cnt: if cnt<len-1, present buf[cnt+1]; else go to PAR.
- **PAR:**
  - pkt_valid=0, pkt_data=par. This is the XOR of the header and all payload bytes.
  - On consume: pulse pkt_done, go to GAP.
- **GAP:**
  - pkt_valid=0, pkt_data=0 for IPG cycles (counted regardless of busy), then IDLE.
- **Latency:** with busy=0 throughout, HDR appears the cycle after the last payload handshake. A packet occupies the router input for len+2 consecutive cycles. The next cmd_ready is asserted IPG+1 cycles after the parity cycle.
- **Inputs outside their state:** cmd_valid outside IDLE and pl_valid outside LOAD are ignored and have no side effects.
- **busy during LOAD/IDLE/GAP:** no effect.
- **Buffer:** a single-port-write, single-port-read array. Pointers never wrap within a packet, since len ≤ DEPTH.

Optional Feature:
- Macro: ROUTER_PKT_PACKER_ERR_INJECT_EN.
- **Defined:**
  - Adds input port inject_err (1 bit).
  - inject_err is sampled at the command handshake. If it was 1, the PAR byte is driven as ~par, so the router reports err.
  - The flag clears on return to IDLE.
- **Undefined:** the port does not exist and parity is always correct.

Test Plan:
- **Basic packet:** busy=0, cmd addr=1 len=3, payload 0x11,0x22,0x33 → after the last pl handshake, pkt_data 0x0D,0x11,0x22,0x33 with pkt_valid=1 on consecutive cycles. Then pkt_data=0x0D with pkt_valid=0 plus a pkt_done pulse, then 1 idle cycle, then cmd_ready=1.
- **Busy stall:** same packet with busy=1 for 2 cycles while 0x22 is presented → 0x22 is held 3 cycles, pkt_valid stays 1 with no gap, and the parity byte is still 0x0D.
- **Illegal commands:** cmd addr=3 len=5, then addr=0 len=0 → each gives a cmd_err pulse, pl_ready stays 0, no pkt_valid; the next legal command proceeds normally.
- **Max length with payload gaps:** addr=2 len=63, bytes 0..62, pl_valid toggling → header 0xFE, payload in order, parity = 0xFE ^ XOR(0..62), cmd_ready back after IPG.
- **Reset mid-packet:** assert reset during PAY → next cycle pkt_valid=0, pkt_data=0, all handshake outputs 0. After deassert, a fresh len=1 packet (addr 0, byte 0xA5, header 0x04) emits 0x04, 0xA5, parity 0xA1.
- **ERR_INJECT_EN:** inject_err=1 with the basic packet → parity byte 0xF2. A following packet with inject_err=0 → correct parity.
